pipeline_controller: RTL and testbench



---
 rtl/pipeline_controller.sv | 226 ++++++++++++++++++++++
 tb/tb_pipeline_controller.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_controller.sv
// Control and hazard unit for the 5-stage ARM pipeline: decode, E/M/W control
// registers, NZCV flags, condition check, forwarding, stall and flush.
// Optional PIPE_CTRL_PERF_EN adds StallCount/FlushCount performance counters.
module pipeline_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic [3:0]  ALUFlagsE,
  input  logic        Match_1E_M,
  input  logic        Match_1E_W,
  input  logic        Match_2E_M,
  input  logic        Match_2E_W,
  input  logic        Match_12D_E,
  output logic [1:0]  RegSrcD,
  output logic [1:0]  ImmSrcD,
  output logic        ALUSrcE,
  output logic [1:0]  ALUControlE,
  output logic        BranchTakenE,
  output logic        MemWriteM,
  output logic        MemtoRegW,
  output logic        PCSrcW,
  output logic        RegWriteW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       pc_src;
    logic       alu_src;
    logic [1:0] alu_control;
    logic [1:0] flag_w;
    logic [3:0] cond;
  } ctrl_e_t;

  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic mem_to_reg;
    logic pc_src;
  } ctrl_m_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic pc_src;
  } ctrl_w_t;

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_instr;

  ctrl_e_t dec_d;
  ctrl_e_t ctrl_e_d, ctrl_e_q;
  ctrl_m_t ctrl_m_d, ctrl_m_q;
  ctrl_w_t ctrl_w_d, ctrl_w_q;
  logic [3:0] flags_d, flags_q;

  logic cond_ex, flag_n, flag_z, flag_c, flag_v;
  logic ldr_stall, pc_wr_pend, branch_taken, flush_e;

  assign op    = InstrD[27:26];
  assign funct = InstrD[25:20];
  assign rd    = InstrD[15:12];
  assign unused_instr = ^{InstrD[19:16], InstrD[11:0]};

  // Decode
  always_comb begin
    dec_d      = '0;
    RegSrcD    = 2'b00;
    ImmSrcD    = 2'b00;
    dec_d.cond = InstrD[31:28];
    case (op)
      2'b00: begin
        dec_d.reg_write = 1'b1;
        dec_d.alu_src   = funct[5];
        case (funct[4:1])
          4'b0100: dec_d.alu_control = 2'b00;
          4'b0010: dec_d.alu_control = 2'b01;
          4'b0000: dec_d.alu_control = 2'b10;
          4'b1100: dec_d.alu_control = 2'b11;
          default: dec_d.alu_control = 2'b00;
        endcase
        dec_d.flag_w[1] = funct[0];
        dec_d.flag_w[0] = funct[0] & ((funct[4:1] == 4'b0100) | (funct[4:1] == 4'b0010));
      end
      2'b01: begin
        dec_d.alu_src     = 1'b1;
        ImmSrcD           = 2'b01;
        dec_d.alu_control = funct[3] ? 2'b00 : 2'b01;
        if (funct[0]) begin
          dec_d.reg_write  = 1'b1;
          dec_d.mem_to_reg = 1'b1;
        end else begin
          dec_d.mem_write = 1'b1;
          RegSrcD         = 2'b10;
        end
      end
      2'b10: begin
        dec_d.branch  = 1'b1;
        dec_d.alu_src = 1'b1;
        ImmSrcD       = 2'b10;
        RegSrcD       = 2'b01;
      end
      default: ;
    endcase
    dec_d.pc_src = ((rd == 4'd15) & dec_d.reg_write) | dec_d.branch;
  end

  // Condition check against the flags committed by earlier instructions only
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (ctrl_e_q.cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~(flag_c & ~flag_z);
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = ~(~flag_z & (flag_n == flag_v));
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    branch_taken = ctrl_e_q.branch & cond_ex;
    ldr_stall    = Match_12D_E & ctrl_e_q.mem_to_reg & ctrl_e_q.reg_write;
    pc_wr_pend   = dec_d.pc_src | ctrl_e_q.pc_src | ctrl_m_q.pc_src;
    flush_e      = ldr_stall | branch_taken;

    flags_d = flags_q;
    if (ctrl_e_q.flag_w[1] & cond_ex) flags_d[3:2] = ALUFlagsE[3:2];
    if (ctrl_e_q.flag_w[0] & cond_ex) flags_d[1:0] = ALUFlagsE[1:0];

    ctrl_e_d = flush_e ? '0 : dec_d;

    ctrl_m_d.reg_write  = ctrl_e_q.reg_write & cond_ex;
    ctrl_m_d.mem_write  = ctrl_e_q.mem_write & cond_ex;
    ctrl_m_d.mem_to_reg = ctrl_e_q.mem_to_reg;
    ctrl_m_d.pc_src     = ctrl_e_q.pc_src & cond_ex;

    ctrl_w_d.reg_write  = ctrl_m_q.reg_write;
    ctrl_w_d.mem_to_reg = ctrl_m_q.mem_to_reg;
    ctrl_w_d.pc_src     = ctrl_m_q.pc_src;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_e_q <= '0;
      ctrl_m_q <= '0;
      ctrl_w_q <= '0;
      flags_q  <= '0;
    end else begin
      ctrl_e_q <= ctrl_e_d;
      ctrl_m_q <= ctrl_m_d;
      ctrl_w_q <= ctrl_w_d;
      flags_q  <= flags_d;
    end
  end

  // M-stage result is newer than W, so it takes priority
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (Match_1E_M & ctrl_m_q.reg_write)      ForwardAE = 2'b10;
    else if (Match_1E_W & ctrl_w_q.reg_write) ForwardAE = 2'b01;
    if (Match_2E_M & ctrl_m_q.reg_write)      ForwardBE = 2'b10;
    else if (Match_2E_W & ctrl_w_q.reg_write) ForwardBE = 2'b01;
  end

  assign ALUSrcE      = ctrl_e_q.alu_src;
  assign ALUControlE  = ctrl_e_q.alu_control;
  assign BranchTakenE = branch_taken;
  assign MemWriteM    = ctrl_m_q.mem_write;
  assign MemtoRegW    = ctrl_w_q.mem_to_reg;
  assign PCSrcW       = ctrl_w_q.pc_src;
  assign RegWriteW    = ctrl_w_q.reg_write;
  assign StallD       = ldr_stall;
  assign StallF       = ldr_stall | pc_wr_pend;
  assign FlushD       = pc_wr_pend | ctrl_w_q.pc_src | branch_taken;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, ldr_stall};
    flush_cnt_d = flush_cnt_q + {31'd0, flush_e};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: reset, forwarding, load-use,
// taken/not-taken branches, conditional store, and optional perf counters.
module tb_pipeline_controller;
  logic        clk, reset;
  logic [31:0] InstrD;
  logic [3:0]  ALUFlagsE;
  logic        Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic [1:0]  RegSrcD, ImmSrcD, ALUControlE, ForwardAE, ForwardBE;
  logic        ALUSrcE, BranchTakenE, MemWriteM, MemtoRegW, PCSrcW, RegWriteW;
  logic        StallF, StallD, FlushD;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] StallCount, FlushCount;
`endif

  localparam logic [31:0] ADD   = 32'hE0821003; // ADD R1,R2,R3
  localparam logic [31:0] SUB   = 32'hE0414005; // SUB R4,R1,R5
  localparam logic [31:0] ADD3  = 32'hE0813004; // ADD R3,R1,R4
  localparam logic [31:0] ORR   = 32'hE1821003; // ORR R1,R2,R3
  localparam logic [31:0] SUBS  = 32'hE0500000; // SUBS R0,R0,R0
  localparam logic [31:0] LDR   = 32'hE5921000; // LDR R1,[R2]
  localparam logic [31:0] STR   = 32'hE5821000; // STR R1,[R2]
  localparam logic [31:0] STRNE = 32'h15821000; // STRNE R1,[R2]
  localparam logic [31:0] BEQ   = 32'h0A000002;
  localparam logic [31:0] BNE   = 32'h1A000002;
  localparam logic [31:0] NOP   = 32'hEC000000; // op=11

  int n_chk = 0;
  int n_bad = 0;

  pipeline_controller dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .ALUFlagsE(ALUFlagsE),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W), .Match_12D_E(Match_12D_E),
    .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .BranchTakenE(BranchTakenE), .MemWriteM(MemWriteM), .MemtoRegW(MemtoRegW),
    .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD)
`ifdef PIPE_CTRL_PERF_EN
    , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // m = {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E}
  task automatic drv(input logic [31:0] i, input logic [4:0] m);
    InstrD = i;
    {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E} = m;
    #1;
  endtask

  task automatic clk1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ALUFlagsE = 4'b0000;
    drv(ADD, 5'b00000);
    clk1;
    chk("rst_regwrite_w", RegWriteW, 0);
    chk("rst_memtoreg_w", MemtoRegW, 0);
    chk("rst_pcsrc_w", PCSrcW, 0);
    chk("rst_memwrite_m", MemWriteM, 0);
    chk("rst_alusrc_e", ALUSrcE, 0);
    chk("rst_branch_e", BranchTakenE, 0);
    chk("rst_stall_f", StallF, 0);
    chk("rst_flush_d", FlushD, 0);
    chk("rst_fwd_a", ForwardAE, 0);
    clk1;
    reset = 1'b0;
    clk1; chk("rw_w_after1", RegWriteW, 0);
    clk1; chk("rw_w_after2", RegWriteW, 0);
    clk1; chk("rw_w_after3", RegWriteW, 1);

    // back-to-back dependency: M and W both match, M wins
    drv(SUB, 5'b00000); clk1;
    drv(NOP, 5'b11100);
    chk("fwd_a_mem", ForwardAE, 2'b10);
    chk("fwd_b_mem", ForwardBE, 2'b10);
    chk("alu_ctl_sub", ALUControlE, 2'b01);
    clk1;
    drv(ADD, 5'b00000); clk1;
    drv(NOP, 5'b00000); clk1;
    drv(SUB, 5'b00000); clk1;
    drv(NOP, 5'b11010); // NOP in M cannot forward even on an address match
    chk("fwd_a_wb", ForwardAE, 2'b01);
    chk("fwd_b_wb", ForwardBE, 2'b01);

    // load-use
    drv(LDR, 5'b00000);
    chk("ldr_immsrc", ImmSrcD, 2'b01);
    chk("ldr_regsrc", RegSrcD, 2'b00);
    clk1;
    drv(ADD3, 5'b00001);
    chk("lu_stall_f", StallF, 1);
    chk("lu_stall_d", StallD, 1);
    chk("lu_flush_d", FlushD, 0);
    chk("ldr_alusrc_e", ALUSrcE, 1);
    chk("ldr_aluctl_e", ALUControlE, 2'b00);
    clk1;
    drv(ADD3, 5'b00001);
    chk("lu_stall_f_end", StallF, 0);
    chk("lu_stall_d_end", StallD, 0);
    chk("lu_bubble_alusrc", ALUSrcE, 0);
    clk1;
    drv(NOP, 5'b01000);
    chk("lu_fwd_a", ForwardAE, 2'b01);
    chk("ldr_memtoreg_w", MemtoRegW, 1);
    chk("ldr_regwrite_w", RegWriteW, 1);

    drv(ORR, 5'b00000); clk1;
    chk("alu_ctl_orr", ALUControlE, 2'b11);

    // SUBS sets Z, then BEQ taken
    drv(SUBS, 5'b00000); clk1;
    ALUFlagsE = 4'b0110;
    drv(BEQ, 5'b00000);
    chk("beqD_stall_f", StallF, 1);
    chk("beqD_flush_d", FlushD, 1);
    chk("beqD_stall_d", StallD, 0);
    chk("beq_regsrc", RegSrcD, 2'b01);
    chk("beq_immsrc", ImmSrcD, 2'b10);
    chk("subsE_branch", BranchTakenE, 0);
    clk1;
    ALUFlagsE = 4'b0000;
    drv(LDR, 5'b00000);
    chk("beq_taken", BranchTakenE, 1);
    chk("beq_flush_d", FlushD, 1);
    clk1;
    drv(NOP, 5'b00000);
    chk("beq_flush_e", ALUSrcE, 0);
    chk("beqM_stall_f", StallF, 1);
    clk1;
    chk("beq_pcsrc_w", PCSrcW, 1);
    chk("beqW_flush_d", FlushD, 1);

    // BNE with Z=1: not taken
    drv(BNE, 5'b00000); clk1;
    drv(LDR, 5'b00000);
    chk("bne_taken", BranchTakenE, 0);
    chk("bne_stall_d", StallD, 0);
    clk1;
    drv(STRNE, 5'b00000);
    chk("bne_no_flush_e", ALUSrcE, 1);
    chk("str_regsrc", RegSrcD, 2'b10);
    clk1;
    chk("bne_pcsrc_w", PCSrcW, 0);
    drv(STR, 5'b00000); clk1;
    drv(NOP, 5'b00000);
    chk("strne_memwrite_m", MemWriteM, 0);
    clk1;
    chk("str_memwrite_m", MemWriteM, 1);

`ifdef PIPE_CTRL_PERF_EN
    chk("stall_count", StallCount, 1);
    chk("flush_count", FlushCount, 2);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
